// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// Receives a length-prefixed byte stream over valid/ready, packs bytes MSB
// first into 32-bit words and drives the memory write port, holding the CPU
// while a load is in progress.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append an XOR checksum
// byte that is verified in a CHECK state before reporting done.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd7
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [ADDR_W:0]   WW_ONE  = 1;

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [ADDR_W:0]     ww_q, ww_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         len_new;
  logic [ADDR_W:0]     ww_inc;
  logic                hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign hs      = rx_valid & rx_ready;
  assign len_new = {len_q[15:8], rx_data};
  assign ww_inc  = ww_q + WW_ONE;

  // Output decode from the current state and the write-port registers
  always_comb begin
    rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
               || (state_q == S_CHECK)
`endif
               ;
    busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    cpu_hold      = busy;
    done          = (state_q == S_DONE);
    error         = (state_q == S_ERROR);
    mem_we        = (state_q == S_WRITE);
    mem_waddr     = waddr_q;
    mem_wdata     = wdata_q;
    words_written = ww_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    widx_d     = widx_q;
    ww_d       = ww_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          byte_cnt_d = '0;
          widx_d     = '0;
          ww_d       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          len_d = len_new;
          if (32'(len_new) > 32'(DEPTH)) begin
            state_d = S_ERROR;
          end else if (len_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          word_d     = {word_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            waddr_d = widx_q;
            wdata_d = {word_q[23:0], rx_data};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        widx_d = widx_q + IDX_ONE;
        ww_d   = ww_inc;
        if (32'(ww_inc) == 32'(len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (hs) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      widx_q     <= '0;
      ww_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      widx_q     <= widx_d;
      ww_q       <= ww_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
